// File: rtl/ecc_pkg.sv
// ecc_pkg: shared types and parity-position constants for the SECDED syndrome path
package ecc_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_SINGLE = 2'b01,
        ERR_DOUBLE = 2'b10
    } err_class_t;

    typedef enum logic [1:0] {
        IDLE,
        GET_MSW,
        CALC,
        OUT
    } state_t;

    localparam int P1_IDX = 1;
    localparam int P2_IDX = 2;
    localparam int P4_IDX = 4;
    localparam int P8_IDX = 8;

    // Bit positions 1..15 covered by parity bit k (those whose index has bit k set)
    function automatic logic [15:0] cover_mask(input int k);
        logic [15:0] m;
        m = '0;
        for (int i = 1; i < 16; i++) m[i] = (i & k) != 0;
        return m;
    endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// ecc_syndrome_calc: maps a 16-bit SECDED codeword to its syndrome and overall parity
module ecc_syndrome_calc
    import ecc_pkg::*;
(
    input  logic [15:0] word,
    output logic [3:0]  syn,
    output logic        par
);

    assign syn = {^(word & cover_mask(P8_IDX)),
                  ^(word & cover_mask(P4_IDX)),
                  ^(word & cover_mask(P2_IDX)),
                  ^(word & cover_mask(P1_IDX))};
    assign par = ^word;

endmodule

// File: rtl/ecc_syndrome_unit.sv
// ecc_syndrome_unit: collects a codeword byte-wise, classifies it and presents the syndrome
module ecc_syndrome_unit
    import ecc_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       pFlip,
    output logic [7:0]       lsw_out,
    output logic [7:0]       msw_out,
    output logic [1:0]       err_class,
    output logic [CNT_W-1:0] single_cnt,
    output logic [CNT_W-1:0] double_cnt
);

    state_t     state;
    logic [3:0] syn;
    logic       par;
    err_class_t cls;

    ecc_syndrome_calc u_calc (
        .word ({msw_out, lsw_out}),
        .syn  (syn),
        .par  (par)
    );

    // Odd overall parity means one flip, even parity with a nonzero syndrome means two
    assign cls = par ? ERR_SINGLE : (syn != 4'd0 ? ERR_DOUBLE : ERR_NONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            pFlip      <= '0;
            lsw_out    <= '0;
            msw_out    <= '0;
            err_class  <= '0;
            single_cnt <= '0;
            double_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        lsw_out <= in_byte;
                        state   <= GET_MSW;
                    end
                end
                GET_MSW: begin
                    if (in_valid && in_ready) begin
                        msw_out  <= in_byte;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    pFlip     <= {4'b0, syn};
                    err_class <= cls;
                    out_valid <= 1'b1;
                    state     <= OUT;
                    if (cls == ERR_SINGLE && single_cnt != '1) single_cnt <= single_cnt + 1'b1;
                    if (cls == ERR_DOUBLE && double_cnt != '1) double_cnt <= double_cnt + 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_syndrome_unit.sv
// tb_ecc_syndrome_unit: table-driven and randomized checks of ecc_syndrome_unit
module tb_ecc_syndrome_unit;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] in_byte = 8'h00;

    logic       in_ready, out_valid;
    logic [7:0] pFlip, lsw_out, msw_out, single_cnt, double_cnt;
    logic [1:0] err_class;

    logic       in_ready_b, out_valid_b;
    logic [7:0] pFlip_b, lsw_out_b, msw_out_b;
    logic [1:0] err_class_b, single_cnt_b, double_cnt_b;

    int total = 0;
    int bad = 0;
    int m_single = 0;
    int m_double = 0;

    typedef struct {
        logic [7:0] lsw;
        logic [7:0] msw;
        logic [7:0] pf;
        int         cls;
    } vec_t;

    vec_t vecs[5];

    ecc_syndrome_unit #(.CNT_W(8)) u_dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .out_valid(out_valid), .out_ready(out_ready), .pFlip(pFlip), .lsw_out(lsw_out),
        .msw_out(msw_out), .err_class(err_class), .single_cnt(single_cnt), .double_cnt(double_cnt)
    );

    ecc_syndrome_unit #(.CNT_W(2)) u_sat (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_byte(in_byte),
        .out_valid(out_valid_b), .out_ready(out_ready), .pFlip(pFlip_b), .lsw_out(lsw_out_b),
        .msw_out(msw_out_b), .err_class(err_class_b), .single_cnt(single_cnt_b), .double_cnt(double_cnt_b)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return v > mx ? mx : v;
    endfunction

    // Reference: syndrome is the XOR of the indices of all set bits 1..15, parity counts all 16
    function automatic logic [4:0] ref_syn(input logic [15:0] w);
        int s = 0;
        int p = 0;
        for (int i = 0; i < 16; i++)
            if (w[i]) begin
                s ^= i;
                p ^= 1;
            end
        return {s[3:0], p[0]};
    endfunction

    task automatic put_byte(input logic [7:0] b);
        int n = 0;
        @(negedge Clk);
        while (!in_ready && n < 20) begin
            @(negedge Clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic finish_word(input string tag, input logic [7:0] l, input logic [7:0] m,
                               input logic [7:0] pf, input int cls, input int hold);
        put_byte(m);
        if (cls == 1) m_single++;
        if (cls == 2) m_double++;
        @(negedge Clk);
        chk({tag, "_calc_ov"}, out_valid, 0);
        @(negedge Clk);
        chk({tag, "_ov"}, out_valid, 1);
        chk({tag, "_pflip"}, pFlip, pf);
        chk({tag, "_class"}, err_class, cls);
        chk({tag, "_lsw"}, lsw_out, l);
        chk({tag, "_msw"}, msw_out, m);
        chk({tag, "_scnt"}, single_cnt, sat(m_single, 255));
        chk({tag, "_dcnt"}, double_cnt, sat(m_double, 255));
        chk({tag, "_scnt2"}, single_cnt_b, sat(m_single, 3));
        chk({tag, "_dcnt2"}, double_cnt_b, sat(m_double, 3));
        if (hold > 0) begin
            repeat (hold) @(negedge Clk);
            chk({tag, "_hold_ov"}, out_valid, 1);
            chk({tag, "_hold_pflip"}, pFlip, pf);
        end
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_word(input string tag, input logic [7:0] l, input logic [7:0] m,
                            input logic [7:0] pf, input int cls, input int hold);
        put_byte(l);
        finish_word(tag, l, m, pf, cls, hold);
    endtask

    task automatic run_model(input string tag, input logic [7:0] l, input logic [7:0] m, input int hold);
        logic [4:0] r;
        r = ref_syn({m, l});
        run_word(tag, l, m, {4'b0, r[4:1]}, r[0] ? 1 : (r[4:1] != 4'd0 ? 2 : 0), hold);
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h00, 8'h00, 0};
        vecs[1] = '{8'h08, 8'h00, 8'h03, 1};
        vecs[2] = '{8'h00, 8'h10, 8'h0C, 1};
        vecs[3] = '{8'h01, 8'h00, 8'h00, 1};
        vecs[4] = '{8'h28, 8'h00, 8'h06, 2};

        @(posedge Clk);
        @(negedge Clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pflip", pFlip, 0);
        chk("rst_class", err_class, 0);
        chk("rst_scnt", single_cnt, 0);
        chk("rst_dcnt", double_cnt, 0);
        Reset = 1'b0;

        for (int i = 0; i < 5; i++) run_word($sformatf("vec%0d", i), vecs[i].lsw, vecs[i].msw, vecs[i].pf, vecs[i].cls, 0);

        // Result held with out_ready low while a new byte is already waiting
        put_byte(8'h08);
        put_byte(8'h00);
        m_single++;
        @(negedge Clk);
        @(negedge Clk);
        chk("hold_start_ov", out_valid, 1);
        in_valid = 1'b1;
        in_byte  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            chk("hold_in_ready", in_ready, 0);
            chk("hold_ov", out_valid, 1);
            chk("hold_pflip", pFlip, 8'h03);
            chk("hold_class", err_class, 1);
            chk("hold_lsw", lsw_out, 8'h08);
            @(negedge Clk);
        end
        out_ready = 1'b1;
        @(posedge Clk);
        #1;
        out_ready = 1'b0;
        @(negedge Clk);
        chk("release_in_ready", in_ready, 1);
        chk("release_ov", out_valid, 0);
        @(posedge Clk);
        #1;
        in_valid = 1'b0;
        @(negedge Clk);
        chk("release_lsw", lsw_out, 8'h55);
        chk("release_getmsw_ready", in_ready, 1);
        begin
            logic [4:0] r;
            r = ref_syn(16'h0055);
            finish_word("after_hold", 8'h55, 8'h00, {4'b0, r[4:1]}, r[0] ? 1 : (r[4:1] != 4'd0 ? 2 : 0), 0);
        end

        for (int i = 0; i < 30; i++)
            run_model($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));

        // Reset with only the LSW taken: nothing may come out and tallies clear
        put_byte(8'h08);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_ov", out_valid, 0);
        chk("midrst_lsw", lsw_out, 0);
        chk("midrst_scnt", single_cnt, 0);
        chk("midrst_dcnt", double_cnt, 0);
        Reset = 1'b0;
        m_single = 0;
        m_double = 0;
        repeat (4) @(negedge Clk);
        chk("midrst_no_output", out_valid, 0);
        chk("midrst_idle_ready", in_ready, 1);

        for (int i = 0; i < 5; i++) run_word($sformatf("sat%0d", i), 8'h08, 8'h00, 8'h03, 1, 0);
        chk("sat_small_cnt", single_cnt_b, 3);
        chk("sat_wide_cnt", single_cnt, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
